// File: rtl/reward_v2_pkg.sv
// Shared types and constants for the reward_v2 packet-composition stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reward_v2_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [WORD_WIDTH-1:0] BROADCAST_ID = 16'hFFFF;
  localparam logic [WORD_WIDTH-1:0] NO_HOP       = 16'hFFFF;

  typedef enum logic [2:0] {
    PKT_HB      = 3'b000,
    PKT_CHE     = 3'b001,
    PKT_INV     = 3'b010,
    PKT_MR      = 3'b011,
    PKT_DATA    = 3'b100,
    PKT_INVALID = 3'b111
  } pktType_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_SCAN,
    ST_READY,
    ST_SEND
  } state_t;

  // Received packet fields captured on en.
  typedef struct packed {
    logic [2:0]            pktType;
    logic [WORD_WIDTH-1:0] sourceID;
    logic [WORD_WIDTH-1:0] sourceHops;
    logic [WORD_WIDTH-1:0] qValue;
    logic [WORD_WIDTH-1:0] energyLeft;
    logic [WORD_WIDTH-1:0] hopsFromCH;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic                  iAmDest;
  } rxPkt_t;

endpackage

// File: rtl/reward_v2_nbr_scan.sv
// Walks the neighbor table one entry per cycle looking for the next-hop ID.
// Latency: one entry compared per cycle while scanEn is high; hit/last are combinational.
// Backpressure: none; the index parks at 0 whenever scanEn is low.
// Ports: clk, nrst (sync, active-high), scanEn, target, neighborCount, mNodeID -> index, hit, last.
module reward_v2_nbr_scan
  import reward_v2_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  scanEn,
  input  logic [WORD_WIDTH-1:0] target,
  input  logic [4:0]            neighborCount,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  output logic [5:0]            index,
  output logic                  hit,
  output logic                  last
);

  assign hit  = (mNodeID == target);
  // Only meaningful with neighborCount > 0; the top never scans an empty table.
  assign last = (index == ({1'b0, neighborCount} - 6'd1));

  always_ff @(posedge clk) begin
    if (nrst) begin
      index <= '0;
    end else if (!scanEn || hit || last) begin
      index <= '0;
    end else begin
      index <= index + 6'd1;
    end
  end

endmodule

// File: rtl/reward_v2.sv
// Builds the outgoing packet (HB/INV ripple, MR, DATA forward) and holds it until okToSend.
// Latency: en -> BUILD next cycle; okToSend in READY -> reward_done[0] on the next cycle.
// Backpressure: packet held in READY until okToSend; en/okToSend ignored in states that do not accept them.
// Ports: node info (my*, role, low_E, iHaveData), received f* fields, KCH/QTUFMB choices,
//        neighbor-table read (nTableIndex_reward -> mNode*), outgoing r* fields, tx_setting, reward_done.
module reward_v2
  import reward_v2_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] timeslot,
  input  logic                  role,
  input  logic                  low_E,
  input  logic                  iHaveData,
  input  logic                  okToSend,
  input  logic                  iAmDestination,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fSourceHops,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  input  logic [4:0]            neighborCount,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  input  logic [WORD_WIDTH-1:0] mNodeCHHops,
  output logic [WORD_WIDTH-1:0] rSourceID,
  output logic [WORD_WIDTH-1:0] rEnergyLeft,
  output logic [WORD_WIDTH-1:0] rQValue,
  output logic [WORD_WIDTH-1:0] rSourceHops,
  output logic [WORD_WIDTH-1:0] rDestinationID,
  output logic [WORD_WIDTH-1:0] rChosenCH,
  output logic [WORD_WIDTH-1:0] rHopsFromCH,
  output logic [2:0]            rPacketType,
  output logic [5:0]            rTimeslot,
  output logic [5:0]            nTableIndex_reward,
  output logic                  tx_setting,
  output logic [15:0]           reward_done
);

  state_t   state;
  rxPkt_t   rxLat;
  logic     selfReq;     // current build was self-initiated by a send opportunity
  pktType_t selfType;
  logic     mrSent;
  logic     doneReg;

  pktType_t buildType;
  logic     buildDrop;
  logic     scanHit;
  logic     scanLast;

  // Fields carried through the stage but not used when composing the reply.
  logic unusedBits;
  assign unusedBits = ^{rxLat.sourceHops, rxLat.qValue, rxLat.energyLeft, rxLat.hopsFromCH,
                        rxLat.chosenCH, mNodeHops, mNodeQValue, mNodeEnergy, timeslot[15:6]};

  assign reward_done = {15'd0, doneReg};

  // Decide what BUILD produces, or whether the received packet is dropped.
  always_comb begin
    buildType = PKT_INVALID;
    buildDrop = 1'b1;
    if (selfReq) begin
      buildType = selfType;
      buildDrop = 1'b0;
    end else begin
      case (rxLat.pktType)
        PKT_HB: begin
          buildType = PKT_HB;
          buildDrop = low_E;
        end
        PKT_INV: begin
          buildType = PKT_INV;
          buildDrop = low_E;
        end
        PKT_DATA: begin
          buildType = PKT_DATA;
          buildDrop = !rxLat.iAmDest;
        end
        default: ;
      endcase
    end
  end

  reward_v2_nbr_scan uScan (
    .clk           (clk),
    .nrst          (nrst),
    .scanEn        (state == ST_SCAN),
    .target        (rDestinationID),
    .neighborCount (neighborCount),
    .mNodeID       (mNodeID),
    .index         (nTableIndex_reward),
    .hit           (scanHit),
    .last          (scanLast)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      state          <= ST_IDLE;
      rxLat          <= '0;
      selfReq        <= 1'b0;
      selfType       <= PKT_HB;
      mrSent         <= 1'b0;
      doneReg        <= 1'b0;
      rSourceID      <= '0;
      rEnergyLeft    <= '0;
      rQValue        <= '0;
      rSourceHops    <= '0;
      rDestinationID <= BROADCAST_ID;
      rChosenCH      <= '0;
      rHopsFromCH    <= '0;
      rPacketType    <= PKT_INVALID;
      rTimeslot      <= '0;
      tx_setting     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          doneReg <= 1'b0;
          if (en) begin
            rxLat   <= '{fPacketType, fSourceID, fSourceHops, fQValue, fEnergyLeft,
                         fHopsFromCH, fChosenCH, iAmDestination};
            selfReq <= 1'b0;
            state   <= ST_BUILD;
          end else if (okToSend) begin
            if (iHaveData && (chosenHop != NO_HOP)) begin
              selfReq  <= 1'b1;
              selfType <= PKT_DATA;
              state    <= ST_BUILD;
            end else if (!role && (chosenCH != '0) && !mrSent) begin
              selfReq  <= 1'b1;
              selfType <= PKT_MR;
              state    <= ST_BUILD;
            end
          end
        end

        ST_BUILD: begin
          if (!selfReq && (rxLat.pktType == PKT_INV)) mrSent <= 1'b0;
          if (buildDrop) begin
            // Nothing to transmit: report completion straight away.
            state   <= ST_SEND;
            doneReg <= 1'b1;
          end else begin
            rSourceID   <= myNodeID;
            rEnergyLeft <= myEnergy;
            rQValue     <= myQValue;
            rSourceHops <= hopsFromSink;
            rPacketType <= buildType;
            state       <= ST_READY;
            case (buildType)
              PKT_HB: begin
                rDestinationID <= BROADCAST_ID;
                tx_setting     <= 1'b0;
              end
              PKT_INV: begin
                rChosenCH      <= rxLat.sourceID;
                rHopsFromCH    <= hopsFromCH;
                rDestinationID <= BROADCAST_ID;
                tx_setting     <= 1'b0;
              end
              PKT_MR: begin
                rDestinationID <= chosenCH;
                rChosenCH      <= chosenCH;
                rHopsFromCH    <= hopsFromCH;
                rTimeslot      <= timeslot[5:0];
                tx_setting     <= 1'b1;
                mrSent         <= 1'b1;
              end
              PKT_DATA: begin
                rDestinationID <= chosenHop;
                tx_setting     <= 1'b1;
                if (neighborCount == 5'd0) rHopsFromCH <= NO_HOP;
                else                       state       <= ST_SCAN;
              end
              default: ;
            endcase
          end
        end

        ST_SCAN: begin
          if (scanHit) begin
            rHopsFromCH <= mNodeCHHops;
            state       <= ST_READY;
          end else if (scanLast) begin
            rHopsFromCH <= NO_HOP;
            state       <= ST_READY;
          end
        end

        ST_READY: begin
          if (okToSend) begin
            state   <= ST_SEND;
            doneReg <= 1'b1;
          end
        end

        ST_SEND: begin
          doneReg <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          doneReg <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reward_v2.sv
// Directed self-checking bench for reward_v2.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_reward_v2;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [15:0] myEnergy, myNodeID, hopsFromSink, myQValue, timeslot;
  logic        role, low_E, iHaveData, okToSend, iAmDestination;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
  logic [15:0] chosenCH, hopsFromCH, chosenHop;
  logic [4:0]  neighborCount;
  logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops;
  logic [15:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
  logic [2:0]  rPacketType;
  logic [5:0]  rTimeslot;
  logic [5:0]  nTableIndex_reward;
  logic        tx_setting;
  logic [15:0] reward_done;

  logic [15:0] tblId  [0:63];
  logic [15:0] tblChh [0:63];

  int total;
  int bad;

  assign mNodeID     = tblId[nTableIndex_reward];
  assign mNodeCHHops = tblChh[nTableIndex_reward];
  assign mNodeHops   = 16'h0001;
  assign mNodeQValue = 16'h0002;
  assign mNodeEnergy = 16'h0003;

  reward_v2 dut (
    .clk(clk), .nrst(nrst), .en(en),
    .myEnergy(myEnergy), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink),
    .myQValue(myQValue), .timeslot(timeslot),
    .role(role), .low_E(low_E), .iHaveData(iHaveData), .okToSend(okToSend),
    .iAmDestination(iAmDestination), .fPacketType(fPacketType),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
    .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
    .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .chosenHop(chosenHop),
    .neighborCount(neighborCount),
    .mNodeID(mNodeID), .mNodeHops(mNodeHops), .mNodeQValue(mNodeQValue),
    .mNodeEnergy(mNodeEnergy), .mNodeCHHops(mNodeCHHops),
    .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft), .rQValue(rQValue),
    .rSourceHops(rSourceHops), .rDestinationID(rDestinationID), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType), .rTimeslot(rTimeslot),
    .nTableIndex_reward(nTableIndex_reward), .tx_setting(tx_setting),
    .reward_done(reward_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) begin
      tblId[i]  = 16'h00EE;
      tblChh[i] = 16'h0077;
    end
    tblId[0] = 16'h0007; tblChh[0] = 16'h0009;
    tblId[1] = 16'h0008; tblChh[1] = 16'h0004;
    tblId[2] = 16'h0005; tblChh[2] = 16'h0002;
    tblId[3] = 16'h0005; tblChh[3] = 16'h0006;

    nrst = 1'b1; en = 1'b0; okToSend = 1'b0;
    myEnergy = 16'h7FFC; myNodeID = 16'h000C; hopsFromSink = 16'h0003; myQValue = 16'h3555;
    timeslot = 16'h0009; role = 1'b0; low_E = 1'b0; iHaveData = 1'b0; iAmDestination = 1'b0;
    fPacketType = 3'b000; fSourceID = 16'h0044; fSourceHops = 16'h0002; fQValue = 16'h1111;
    fEnergyLeft = 16'h2222; fHopsFromCH = 16'h0001; fChosenCH = 16'h0033;
    chosenCH = 16'h0000; hopsFromCH = 16'h0001; chosenHop = 16'hFFFF; neighborCount = 5'd0;

    // Reset state
    tick(); tick();
    nrst = 1'b0;
    check("rst_type",  rPacketType, 3'b111);
    check("rst_dest",  rDestinationID, 16'hFFFF);
    check("rst_src",   rSourceID, 16'h0000);
    check("rst_tx",    tx_setting, 1'b0);
    check("rst_done",  reward_done, 16'h0000);
    check("rst_index", nTableIndex_reward, 6'd0);

    // 1. Received HB, granted 7 cycles after en
    en = 1'b1; fPacketType = 3'b000;
    tick();
    en = 1'b0;
    check("hb_nodone_build", reward_done, 16'h0000);
    tick();
    repeat (5) tick();
    check("hb_nodone_wait", reward_done, 16'h0000);
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    check("hb_done",  reward_done, 16'h0001);
    check("hb_type",  rPacketType, 3'b000);
    check("hb_src",   rSourceID, 16'h000C);
    check("hb_hops",  rSourceHops, 16'h0003);
    check("hb_q",     rQValue, 16'h3555);
    check("hb_energy", rEnergyLeft, 16'h7FFC);
    check("hb_dest",  rDestinationID, 16'hFFFF);
    check("hb_tx",    tx_setting, 1'b0);
    tick();
    check("hb_done_1cyc", reward_done, 16'h0000);

    // 2. Self-initiated MR; the grant seen during BUILD is not consumed
    chosenCH = 16'h0023; hopsFromCH = 16'h0001;
    okToSend = 1'b1;
    tick();
    tick();
    okToSend = 1'b0;
    check("mr_nodone_build", reward_done, 16'h0000);
    check("mr_type_ready", rPacketType, 3'b011);
    tick();
    check("mr_nodone_ready", reward_done, 16'h0000);
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    check("mr_done",  reward_done, 16'h0001);
    check("mr_dest",  rDestinationID, 16'h0023);
    check("mr_ch",    rChosenCH, 16'h0023);
    check("mr_hch",   rHopsFromCH, 16'h0001);
    check("mr_tx",    tx_setting, 1'b1);
    check("mr_slot",  rTimeslot, 6'd9);
    tick();
    okToSend = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_second_grant_nodone", reward_done, 16'h0000);
    end
    okToSend = 1'b0;
    tick();

    // 3. Self-initiated DATA with a neighbor-table hit at entry 2
    iHaveData = 1'b1; chosenHop = 16'h0005; neighborCount = 5'd3;
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    tick();
    check("data_idx0",  nTableIndex_reward, 6'd0);
    check("data_type",  rPacketType, 3'b100);
    check("data_dest",  rDestinationID, 16'h0005);
    check("data_tx",    tx_setting, 1'b1);
    tick();
    check("data_idx1",  nTableIndex_reward, 6'd1);
    tick();
    check("data_idx2",  nTableIndex_reward, 6'd2);
    tick();
    check("data_idx_back0", nTableIndex_reward, 6'd0);
    check("data_hch",   rHopsFromCH, 16'h0002);
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    check("data_done",  reward_done, 16'h0001);
    iHaveData = 1'b0;
    tick();
    check("data_done_1cyc", reward_done, 16'h0000);

    // 3b. DATA with no table match
    iHaveData = 1'b1; chosenHop = 16'h000A; neighborCount = 5'd2;
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    tick(); tick(); tick();
    check("nomatch_hch",  rHopsFromCH, 16'hFFFF);
    check("nomatch_dest", rDestinationID, 16'h000A);
    check("nomatch_idx",  nTableIndex_reward, 6'd0);
    okToSend = 1'b1;
    tick();
    okToSend = 1'b0;
    check("nomatch_done", reward_done, 16'h0001);
    iHaveData = 1'b0;
    tick();

    // 4. INV with low_E dropped; invalid type dropped
    low_E = 1'b1; en = 1'b1; fPacketType = 3'b010; fSourceID = 16'h0044;
    tick();
    en = 1'b0;
    check("inv_lowe_nodone", reward_done, 16'h0000);
    tick();
    check("inv_lowe_done", reward_done, 16'h0001);
    check("inv_lowe_type_held", rPacketType, 3'b100);
    tick();
    check("inv_lowe_done_1cyc", reward_done, 16'h0000);
    en = 1'b1; fPacketType = 3'b111;
    tick();
    en = 1'b0;
    check("invalid_nodone", reward_done, 16'h0000);
    tick();
    check("invalid_done", reward_done, 16'h0001);
    tick();
    // The received INV cleared mrSent, so a new MR may go out.
    low_E = 1'b0;
    okToSend = 1'b1;
    tick(); tick(); tick();
    okToSend = 1'b0;
    check("mr_again_done", reward_done, 16'h0001);
    check("mr_again_type", rPacketType, 3'b011);
    tick();

    // Received INV without low_E, left waiting in READY
    chosenCH = 16'h0000;
    en = 1'b1; fPacketType = 3'b010; fSourceID = 16'h0044;
    tick();
    en = 1'b0;
    tick();
    check("inv_type", rPacketType, 3'b010);
    check("inv_ch",   rChosenCH, 16'h0044);
    check("inv_dest", rDestinationID, 16'hFFFF);
    check("inv_tx",   tx_setting, 1'b0);

    // 5. Reset while in READY
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    check("rst2_type", rPacketType, 3'b111);
    check("rst2_dest", rDestinationID, 16'hFFFF);
    check("rst2_ch",   rChosenCH, 16'h0000);
    check("rst2_src",  rSourceID, 16'h0000);
    check("rst2_done", reward_done, 16'h0000);
    okToSend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst2_grant_nodone", reward_done, 16'h0000);
    end
    okToSend = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
